// File: rtl/sigalign.sv
// sigalign: floating-point adder alignment stage (double precision).
// Picks the larger-exponent operand and right-shifts the other significand by
// the exponent difference, folding shifted-out bits into a sticky bit.
// Latency 2 cycles accept-to-out_valid; 1 op/cycle with out_ready high;
// two-slot valid/ready pipeline, in_ready combinational from out_ready.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   input handshake
//   ea, eb, fa, fb      exponents (11b) and 1.52 significands (53b) of A, B
//   sa, sb, sub         operand signs and subtract opcode
//   out_valid/out_ready output handshake
//   es, fa2             result exponent and larger-exponent significand
//   fb3                 aligned other significand {0, [54:2] aligned, guard, sticky}
//   sa2, sb2, sx        larger sign, effective other sign, effective subtraction
module sigalign (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] ea,
  input  logic [10:0] eb,
  input  logic [52:0] fa,
  input  logic [52:0] fb,
  input  logic        sa,
  input  logic        sb,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] es,
  output logic [52:0] fa2,
  output logic [55:0] fb3,
  output logic        sa2,
  output logic        sb2,
  output logic        sx
);

  // S1 registers
  logic        r_v1;
  logic [10:0] r_el1;
  logic [10:0] r_d1;
  logic [52:0] r_fl1;
  logic [52:0] r_fs1;
  logic        r_sl1;
  logic        r_ss1;
  logic        r_sx1;

  // S2 registers (drive the outputs directly)
  logic        r_v2;
  logic [10:0] r_es;
  logic [52:0] r_fa2;
  logic [55:0] r_fb3;
  logic        r_sa2;
  logic        r_sb2;
  logic        r_sx2;

  logic        w_s1_load;
  logic        w_s2_load;
  logic        w_swap;
  logic        w_sbe;
  logic [10:0] w_el;
  logic [10:0] w_esm;
  logic [53:0] w_t;
  logic [53:0] w_mask;
  logic [55:0] w_fb3;

  // S2 may take a new op whenever it is empty or its current op leaves this cycle.
  assign w_s2_load = r_v1 & (~r_v2 | out_ready);
  assign w_s1_load = in_valid & (~r_v1 | w_s2_load);
  assign in_ready  = ~r_v1 | ~r_v2 | out_ready;

  assign w_sbe  = sb ^ sub;
  assign w_swap = (eb > ea);
  assign w_el   = w_swap ? eb : ea;
  assign w_esm  = w_swap ? ea : eb;

  // Alignment shifter with sticky collection. Shifts of 54 or more push every
  // significand bit (plus the guard slot) below the sticky position.
  always_comb begin
    w_t    = {r_fs1, 1'b0};
    w_mask = '0;
    w_fb3  = {55'd0, |r_fs1};
    if (r_d1 < 11'd54) begin
      w_mask = (54'd1 << r_d1) - 54'd1;
      w_fb3  = {1'b0, w_t >> r_d1, |(w_t & w_mask)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_el1 <= '0;
      r_d1  <= '0;
      r_fl1 <= '0;
      r_fs1 <= '0;
      r_sl1 <= 1'b0;
      r_ss1 <= 1'b0;
      r_sx1 <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_v1 <= 1'b1;
      end else if (w_s2_load) begin
        r_v1 <= 1'b0;
      end
      // Data only changes on load; a drain leaves the registers untouched.
      if (w_s1_load) begin
        r_el1 <= w_el;
        r_d1  <= w_el - w_esm;
        r_fl1 <= w_swap ? fb : fa;
        r_fs1 <= w_swap ? fa : fb;
        r_sl1 <= w_swap ? w_sbe : sa;
        r_ss1 <= w_swap ? sa : w_sbe;
        r_sx1 <= sa ^ w_sbe;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2  <= 1'b0;
      r_es  <= '0;
      r_fa2 <= '0;
      r_fb3 <= '0;
      r_sa2 <= 1'b0;
      r_sb2 <= 1'b0;
      r_sx2 <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_v2 <= 1'b1;
      end else if (out_ready) begin
        r_v2 <= 1'b0;
      end
      if (w_s2_load) begin
        r_es  <= r_el1;
        r_fa2 <= r_fl1;
        r_fb3 <= w_fb3;
        r_sa2 <= r_sl1;
        r_sb2 <= r_ss1;
        r_sx2 <= r_sx1;
      end
    end
  end

  assign out_valid = r_v2;
  assign es        = r_es;
  assign fa2       = r_fa2;
  assign fb3       = r_fb3;
  assign sa2       = r_sa2;
  assign sb2       = r_sb2;
  assign sx        = r_sx2;

endmodule

// File: tb/tb_sigalign.sv
// Bench for sigalign: directed literal cases, backpressure, mid-flight reset,
// then randomized traffic checked every cycle against a transaction-queue model.
module tb_sigalign;

  typedef struct packed {
    logic [10:0] ea;
    logic [10:0] eb;
    logic [52:0] fa;
    logic [52:0] fb;
    logic        sa;
    logic        sb;
    logic        sub;
  } op_t;

  typedef struct packed {
    logic [10:0] es;
    logic [52:0] fa2;
    logic [55:0] fb3;
    logic        sa2;
    logic        sb2;
    logic        sx;
  } res_t;

  typedef struct packed {
    res_t        r;
    logic [31:0] cyc;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] ea, eb;
  logic [52:0] fa, fb;
  logic        sa, sb, sub;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] es;
  logic [52:0] fa2;
  logic [55:0] fb3;
  logic        sa2, sb2, sx;

  int          checks;
  int          errors;
  logic [31:0] cyc;
  int          n_out;
  logic        last_acc;
  logic        last_ir;
  ent_t        q[$];

  sigalign dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ea(ea), .eb(eb), .fa(fa), .fb(fb), .sa(sa), .sb(sb), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .es(es), .fa2(fa2), .fb3(fb3), .sa2(sa2), .sb2(sb2), .sx(sx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pick larger exponent, then place the small significand in a
  // wide field and shift; everything that falls below the guard slot is sticky.
  function automatic res_t model(input op_t o);
    res_t         r;
    logic         sw, sbe;
    logic [10:0]  el, esm, d;
    logic [52:0]  fl, fsm;
    logic [117:0] ext;
    sbe   = o.sb ^ o.sub;
    sw    = o.eb > o.ea;
    el    = sw ? o.eb : o.ea;
    esm   = sw ? o.ea : o.eb;
    fl    = sw ? o.fb : o.fa;
    fsm   = sw ? o.fa : o.fb;
    d     = el - esm;
    r.es  = el;
    r.fa2 = fl;
    r.sa2 = sw ? sbe : o.sa;
    r.sb2 = sw ? o.sa : sbe;
    r.sx  = o.sa ^ sbe;
    if (d < 11'd54) begin
      ext   = {fsm, 65'd0} >> d;
      r.fb3 = {1'b0, ext[117:64], |ext[63:0]};
    end else begin
      r.fb3 = {55'd0, |fsm};
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic compare();
    logic exp_ov;
    res_t got;
    exp_ov = (q.size() > 0) && (cyc > q[0].cyc);
    checks++;
    if (out_valid !== exp_ov) begin
      errors++;
      $display("FAIL out_valid cyc %0d got %b expected %b", cyc, out_valid, exp_ov);
    end
    if (out_valid === 1'b1 && q.size() > 0) begin
      got = {es, fa2, fb3, sa2, sb2, sx};
      checks++;
      if (got !== q[0].r) begin
        errors++;
        $display("FAIL data cyc %0d got es=%h fa2=%h fb3=%h s=%b%b%b expected es=%h fa2=%h fb3=%h s=%b%b%b",
                 cyc, es, fa2, fb3, sa2, sb2, sx, q[0].r.es, q[0].r.fa2, q[0].r.fb3,
                 q[0].r.sa2, q[0].r.sb2, q[0].r.sx);
      end
    end
  endtask

  // One clock: drive at negedge, update model at posedge, compare at next negedge.
  task automatic cycle(input logic iv, input op_t o, input logic ordy);
    logic xf;
    ent_t e;
    in_valid  = iv;
    ea = o.ea; eb = o.eb; fa = o.fa; fb = o.fb;
    sa = o.sa; sb = o.sb; sub = o.sub;
    out_ready = ordy;
    #1;
    chk("in_ready", 64'(in_ready), 64'((q.size() < 2) || ordy));
    last_ir  = in_ready;
    last_acc = in_valid & in_ready;
    xf       = out_valid & out_ready;
    @(posedge clk);
    cyc++;
    if (xf) begin
      if (q.size() > 0) void'(q.pop_front());
      n_out++;
    end
    if (last_acc) begin
      e.r   = model(o);
      e.cyc = cyc;
      q.push_back(e);
    end
    @(negedge clk);
    compare();
  endtask

  function automatic op_t mk(input int a, input int b, input logic [52:0] xa,
                             input logic [52:0] xb, input logic xsa, input logic xsb,
                             input logic xsub);
    op_t o;
    o.ea = 11'(a); o.eb = 11'(b); o.fa = xa; o.fb = xb;
    o.sa = xsa; o.sb = xsb; o.sub = xsub;
    return o;
  endfunction

  // Send one op, hold it at the output, check literal values, then drain.
  task automatic lit(input string nm, input op_t o, input res_t exp);
    op_t  idle;
    res_t m;
    idle = '0;
    m = model(o);
    chk({nm, "_model"}, 64'(m == exp), 64'd1);
    cycle(1'b1, o, 1'b0);
    cycle(1'b0, idle, 1'b0);
    chk({nm, "_ov"},  64'(out_valid), 64'd1);
    chk({nm, "_es"},  64'(es), 64'(exp.es));
    chk({nm, "_fa2"}, 64'(fa2), 64'(exp.fa2));
    chk({nm, "_fb3"}, 64'(fb3), 64'(exp.fb3));
    chk({nm, "_sgn"}, 64'({sa2, sb2, sx}), 64'({exp.sa2, exp.sb2, exp.sx}));
    cycle(1'b0, idle, 1'b1);
  endtask

  function automatic logic [52:0] rsig();
    logic [52:0] v;
    v = 53'({$urandom(), $urandom()});
    if ($urandom_range(7, 0) != 0) v[52] = 1'b1;
    if ($urandom_range(9, 0) == 0) v = '0;
    return v;
  endfunction

  function automatic op_t rop();
    op_t o;
    int  d;
    o.ea = 11'($urandom_range(2046, 0));
    d = $urandom_range(60, 0);
    case ($urandom_range(3, 0))
      0: o.eb = o.ea;
      1: o.eb = (int'(o.ea) >= d) ? 11'(int'(o.ea) - d) : 11'(int'(o.ea) + d);
      2: o.eb = (int'(o.ea) + d <= 2046) ? 11'(int'(o.ea) + d) : 11'(int'(o.ea) - d);
      default: o.eb = 11'($urandom_range(2046, 0));
    endcase
    o.fa  = rsig();
    o.fb  = rsig();
    o.sa  = 1'($urandom_range(1, 0));
    o.sb  = 1'($urandom_range(1, 0));
    o.sub = 1'($urandom_range(1, 0));
    return o;
  endfunction

  initial begin
    op_t  idle;
    op_t  bp[4];
    int   idx, acc_n, first_block, out0, c;
    checks = 0; errors = 0; cyc = 0; n_out = 0;
    idle = '0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ea = '0; eb = '0; fa = '0; fb = '0; sa = 1'b0; sb = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready), 64'd1);
    chk("rst_data", 64'(|{es, fa2, fb3, sa2, sb2, sx}), 64'd0);
    rst_n = 1'b1;

    lit("aligned", mk(1023, 1021, 53'h10000000000000, 53'h18000000000000, 0, 0, 0),
        '{11'd1023, 53'h10000000000000, 56'h18000000000000, 1'b0, 1'b0, 1'b0});
    lit("swapsub", mk(1000, 1003, 53'h10000000000000, 53'h1F000000000000, 0, 0, 1),
        '{11'd1003, 53'h1F000000000000, 56'h08000000000000, 1'b1, 1'b0, 1'b1});
    lit("sticky", mk(1026, 1023, 53'h10000000000000, 53'h1FFFFFFFFFFFFF, 0, 0, 0),
        '{11'd1026, 53'h10000000000000, 56'h0FFFFFFFFFFFFF, 1'b0, 1'b0, 1'b0});
    lit("far", mk(2010, 10, 53'h10000000000000, 53'h1FFFFFFFFFFFFF, 0, 0, 0),
        '{11'd2010, 53'h10000000000000, 56'h1, 1'b0, 1'b0, 1'b0});
    lit("equal", mk(1023, 1023, 53'h10000000000000, 53'h10000000000000, 1, 0, 0),
        '{11'd1023, 53'h10000000000000, 56'h40000000000000, 1'b1, 1'b0, 1'b1});
    lit("d53", mk(1076, 1023, 53'h10000000000000, 53'h10000000000000, 0, 1, 1),
        '{11'd1076, 53'h10000000000000, 56'h2, 1'b0, 1'b0, 1'b0});
    lit("d54", mk(1077, 1023, 53'h10000000000000, 53'h10000000000000, 0, 1, 0),
        '{11'd1077, 53'h10000000000000, 56'h1, 1'b0, 1'b1, 1'b1});

    // Backpressure: four ops back-to-back, out_ready low on cycles 3..6.
    for (int i = 0; i < 4; i++) bp[i] = rop();
    idx = 0; acc_n = 0; first_block = -1; out0 = n_out;
    for (c = 1; c <= 40 && (idx < 4 || q.size() > 0); c++) begin
      cycle(idx < 4, bp[(idx < 4) ? idx : 0], !(c >= 3 && c <= 6));
      if (idx < 4 && !last_ir && first_block < 0) first_block = acc_n;
      if (last_acc) begin idx++; acc_n++; end
    end
    chk("bp_block_after", 64'(first_block), 64'd2);
    chk("bp_emitted", 64'(n_out - out0), 64'd4);
    chk("bp_drained", 64'(q.size()), 64'd0);

    // Reset with both stages occupied.
    cycle(1'b1, rop(), 1'b0);
    cycle(1'b1, rop(), 1'b0);
    chk("mid_full", 64'(out_valid & ~in_ready), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(|{es, fa2, fb3, sa2, sb2, sx}), 64'd0);
    chk("mid_rst_ir", 64'(in_ready), 64'd1);
    q.delete();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0, idle, 1'b1);

    // Randomized traffic with random stalls on both sides.
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(9, 0) < 7, rop(), $urandom_range(9, 0) < 7);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, idle, 1'b1);
    chk("final_drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
